// File: rtl/demux2_stream_pkg.sv
// Shared defaults and slot state encoding for the two-way stream demultiplexer.
package demux2_stream_pkg;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/demux2_stream_slot.sv
// One-entry register slot with drain-and-reload in the same cycle and a
// wrapping count of completed output transfers.
module stream_slot
   import demux2_stream_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             loadable,
   output logic [CNT_W-1:0] cnt
);

   slot_state_t      state;
   slot_state_t      state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             drain;

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   // A load always wins: the slot stays or becomes FULL with the new word.
   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY:   if (load)           state_nxt = FULL;
         FULL:    if (ready && !load) state_nxt = EMPTY;
         default:                     state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      valid    = 1'b0;
      loadable = 1'b0;
      valid    = (state == FULL);
      loadable = (state == EMPTY) || ready;
   end

   assign drain = valid && ready;

   always_ff @(posedge clk) begin
      if (reset)     data_q <= '0;
      else if (load) data_q <= load_data;
   end

   always_ff @(posedge clk) begin
      if (reset)      cnt_q <= '0;
      else if (drain) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign data = data_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/demux2_stream.sv
// Routes each accepted input word to one of two independent one-entry output
// slots; a stalled port never blocks the other one.
module demux2_stream
   import demux2_stream_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic loadable0;
   logic loadable1;
   logic load0;
   logic load1;

   // in_ready follows the selected slot, so outN_ready reaches it combinationally.
   assign in_ready = in_sel ? loadable1 : loadable0;
   assign load0    = in_valid && !in_sel && loadable0;
   assign load1    = in_valid &&  in_sel && loadable1;

   stream_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot0 (
      .clk       (clk),
      .reset     (reset),
      .load      (load0),
      .load_data (in_data),
      .ready     (out0_ready),
      .valid     (out0_valid),
      .data      (out0_data),
      .loadable  (loadable0),
      .cnt       (cnt0)
   );

   stream_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_slot1 (
      .clk       (clk),
      .reset     (reset),
      .load      (load1),
      .load_data (in_data),
      .ready     (out1_ready),
      .valid     (out1_valid),
      .data      (out1_data),
      .loadable  (loadable1),
      .cnt       (cnt1)
   );

endmodule

// File: tb/tb_demux2_stream.sv
// Directed and random checks of demux2_stream against a queue-based model.
module tb_demux2_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_sel;
   logic       out0_valid;
   logic       out0_ready;
   logic [3:0] out0_data;
   logic       out1_valid;
   logic       out1_ready;
   logic [3:0] out1_data;
   logic [7:0] cnt0;
   logic [7:0] cnt1;

   int checks   = 0;
   int failures = 0;

   // Model: each port is a FIFO of capacity one plus a wrapping transfer count.
   logic [3:0] q0[$];
   logic [3:0] q1[$];
   logic [7:0] mcnt0 = 8'd0;
   logic [7:0] mcnt1 = 8'd0;

   demux2_stream #(.WIDTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out0_data  (out0_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare outputs against the model, apply one clock edge, then update the model.
   task automatic step(input logic v, input logic s, input logic [3:0] d,
                       input logic r0, input logic r1, input logic rst);
      logic l0, l1, exp_rdy;
      reset = rst; in_valid = v; in_sel = s; in_data = d;
      out0_ready = r0; out1_ready = r1;
      #1;
      l0      = (q0.size() == 0) || r0;
      l1      = (q1.size() == 0) || r1;
      exp_rdy = s ? l1 : l0;
      if (!rst) chk("in_ready", 8'(in_ready), 8'(exp_rdy));
      chk("out0_valid", 8'(out0_valid), 8'(q0.size() != 0));
      chk("out1_valid", 8'(out1_valid), 8'(q1.size() != 0));
      if (q0.size() != 0) chk("out0_data", 8'(out0_data), 8'(q0[0]));
      if (q1.size() != 0) chk("out1_data", 8'(out1_data), 8'(q1[0]));
      chk("cnt0", cnt0, mcnt0);
      chk("cnt1", cnt1, mcnt1);
      @(posedge clk);
      if (rst) begin
         q0.delete(); q1.delete();
         mcnt0 = 8'd0; mcnt1 = 8'd0;
      end else begin
         if (q0.size() != 0 && r0) begin void'(q0.pop_front()); mcnt0 = mcnt0 + 8'd1; end
         if (q1.size() != 0 && r1) begin void'(q1.pop_front()); mcnt1 = mcnt1 + 8'd1; end
         if (v && exp_rdy) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] c0_prev;
      reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 4'h0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      @(negedge clk); @(negedge clk);

      // Reset state
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_out0_valid", 8'(out0_valid), 8'h00);
      chk("rst_out1_valid", 8'(out1_valid), 8'h00);
      chk("rst_out0_data", 8'(out0_data), 8'h00);
      chk("rst_out1_data", 8'(out1_data), 8'h00);
      chk("rst_cnt0", cnt0, 8'h00);
      chk("rst_cnt1", cnt1, 8'h00);

      // Single word to port 0, one-cycle latency, then drained
      step(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0);
      chk("lat_out0_valid", 8'(out0_valid), 8'h01);
      chk("lat_out0_data", 8'(out0_data), 8'h0A);
      chk("lat_out1_valid", 8'(out1_valid), 8'h00);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("lat_cnt0", cnt0, 8'h01);

      // Stalled port 1 holds its word and does not block port 0
      step(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
      chk("stall_out1_data", 8'(out1_data), 8'h03);
      in_sel = 1'b1; #1;
      chk("stall_in_ready", 8'(in_ready), 8'h00);
      step(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
      chk("bypass_out0_data", 8'(out0_data), 8'h07);
      chk("bypass_out1_data", 8'(out1_data), 8'h03);

      // Drain and reload port 0 in the same cycle
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
      c0_prev = mcnt0;
      in_sel = 1'b0; out0_ready = 1'b1; #1;
      chk("reload_in_ready", 8'(in_ready), 8'h01);
      step(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
      chk("reload_out0_data", 8'(out0_data), 8'h02);
      chk("reload_out0_valid", 8'(out0_valid), 8'h01);
      chk("reload_cnt0", cnt0, c0_prev + 8'd1);

      // Both full, simultaneous drain on both ports
      step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      chk("both_out0_valid", 8'(out0_valid), 8'h00);
      chk("both_out1_valid", 8'(out1_valid), 8'h00);
      chk("both_cnt0", cnt0, c0_prev + 8'd2);

      // Reset while both full and both ready: no transfer counted
      step(1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hD, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'hE, 1'b1, 1'b1, 1'b1);
      chk("midrst_out0_valid", 8'(out0_valid), 8'h00);
      chk("midrst_out1_valid", 8'(out1_valid), 8'h00);
      chk("midrst_cnt0", cnt0, 8'h00);
      chk("midrst_cnt1", cnt1, 8'h00);

      // 256 transfers out of port 1 wrap its counter
      for (int i = 0; i < 256; i++)
         step(1'b1, 1'b1, 4'($urandom), 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
      chk("wrap_cnt1", cnt1, 8'h00);
      chk("wrap_out1_valid", 8'(out1_valid), 8'h00);

      // Random traffic with occasional reset
      for (int i = 0; i < 600; i++)
         step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 49) == 0));
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
